// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expander_if
//  Description : Control and round-key stream bundle for aes_key_expander.
//                Groups the start/key request side and the valid/ready
//                round-key stream that feeds the AddRoundKey XOR stage.
//  Signals     : start    - begin expansion of key_in (sampled in IDLE)
//                key_in   - 128-bit cipher key, [127:120] is byte 0
//                dec      - 0 = emit rounds 0..10, 1 = emit rounds 10..0
//                rk_ready - consumer accepts the current round key
//                rk_valid - rk_out / rk_round hold a valid round key
//                rk_out   - round key, same byte order as key_in
//                rk_round - round index of rk_out (0..10)
//                busy     - expansion or emission in progress
//                done     - one-cycle pulse after the final handshake
//  Modports    : master - requester / stream consumer side
//                slave  - key expander side
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_key_expander_if;
    logic         start;
    logic [127:0] key_in;
    logic         dec;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, dec, rk_ready,
        input  rk_valid, rk_out, rk_round, busy, done
    );

    modport slave (
        input  start, key_in, dec, rk_ready,
        output rk_valid, rk_out, rk_round, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : SBox
//  Description : AES forward S-box applied bytewise to a 128-bit word.
//                Shared substitution definition for the data path and the
//                key schedule.
//  Ports       : in_data  - 16 input bytes
//                out_data - 16 substituted bytes (same positions)
//  Revision    : 1.0 - initial release
// ============================================================================
module SBox (
    input  logic [127:0] in_data,
    output logic [127:0] out_data
);
    // Entry 0 sits in the most significant byte, so entry x lives at byte
    // offset (255 - x) == ~x counted from the LSB end.
    localparam logic [2047:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign out_data[8*i +: 8] = c_sbox_table[{~in_data[8*i +: 8], 3'b000} +: 8];
    end
endmodule

// ============================================================================
//  Module      : aes_key_expander
//  Description : Iterative AES-128 key schedule. On start it expands the
//                cipher key into 11 round keys, one per cycle, holds them in
//                a register file, then streams them over valid/ready in
//                forward (encrypt) or reverse (decrypt) order.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                kif   - aes_key_expander_if.slave (start/key_in/dec in,
//                        rk_valid/rk_out/rk_round/busy/done out, rk_ready in)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_key_expander #(
    parameter int DEPTH = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    aes_key_expander_if.slave   kif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    localparam logic [3:0] c_last_idx = 4'(DEPTH - 1);

    state_t         r_state;
    state_t         w_state_nxt;

    logic [127:0]   r_rk [DEPTH];
    logic [3:0]     r_round;        // round being generated during EXPAND
    logic [3:0]     r_emit;         // round index currently presented
    logic           r_dec;
    logic           r_done;

    logic           w_hs;
    logic           w_final_hs;

    logic [3:0]     w_prev_idx;
    logic [127:0]   w_prev;
    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [31:0]    w_rot;
    logic [127:0]   w_sbox_out;
    logic [95:0]    w_sbox_unused;
    logic [31:0]    w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_rk_next;

    // ------------------------------------------------------------------
    // Round constant for round r (1..10)
    // ------------------------------------------------------------------
    function automatic logic [7:0] f_rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // One key-schedule round: rk[r] from rk[r-1]
    // ------------------------------------------------------------------
    // Guard keeps the read index inside the register file while idle.
    assign w_prev_idx = (r_round == 4'd0) ? 4'd0 : (r_round - 4'd1);
    assign w_prev     = r_rk[w_prev_idx];

    assign w_w0 = w_prev[127:96];
    assign w_w1 = w_prev[95:64];
    assign w_w2 = w_prev[63:32];
    assign w_w3 = w_prev[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    // Only the low word carries RotWord; the upper 96 bits are constant
    // substitutions of zero and are discarded.
    SBox u_sbox (
        .in_data  ({96'h0, w_rot}),
        .out_data (w_sbox_out)
    );
    assign w_sbox_unused = w_sbox_out[127:32];

    assign w_t  = w_sbox_out[31:0] ^ {f_rcon(r_round), 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

    // ------------------------------------------------------------------
    // Stream handshake
    // ------------------------------------------------------------------
    assign w_hs       = (r_state == S_EMIT) && kif.rk_ready;
    assign w_final_hs = w_hs && (r_dec ? (r_emit == 4'd0) : (r_emit == c_last_idx));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (kif.start) begin
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (r_round == c_last_idx) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_final_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: register file, counters, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rk[i] <= '0;
            end
            r_round <= 4'd0;
            r_emit  <= 4'd0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_final_hs;
            case (r_state)
                S_IDLE: begin
                    if (kif.start) begin
                        r_rk[0] <= kif.key_in;
                        r_dec   <= kif.dec;
                        r_round <= 4'd1;
                        r_emit  <= kif.dec ? c_last_idx : 4'd0;
                    end
                end
                S_EXPAND: begin
                    r_rk[r_round] <= w_rk_next;
                    r_round       <= r_round + 4'd1;
                end
                S_EMIT: begin
                    // The index holds on the final beat so it never leaves
                    // the register file range.
                    if (w_hs && !w_final_hs) begin
                        r_emit <= r_dec ? (r_emit - 4'd1) : (r_emit + 4'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign kif.rk_valid = (r_state == S_EMIT);
    assign kif.busy     = (r_state != S_IDLE);
    assign kif.done     = r_done;
    assign kif.rk_out   = r_rk[r_emit];
    assign kif.rk_round = r_emit;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expander
//  Description : Directed self-checking bench for aes_key_expander using the
//                FIPS-197 example key and the all-zero key.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_expander;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [127:0] fips_tbl [0:10];
    logic [127:0] zero_tbl [0:10];
    bit           zero_known [0:10];

    localparam logic [127:0] c_fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expander_if kif ();

    aes_key_expander #(.DEPTH(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one start/expand/emit transaction; called and returning on a
    // falling edge.
    task automatic run_seq(input string name, input logic [127:0] key, input logic dec_i,
                           input bit use_zero, input bit rnd, input bit inject);
        int           cyc;
        int           k;
        int           idx;
        bit           stalled;
        bit           saw_done;
        bit           rdy;
        logic [127:0] prev_out;
        logic [3:0]   prev_round;
        prev_out   = '0;
        prev_round = '0;

        kif.start    = 1'b1;
        kif.key_in   = key;
        kif.dec      = dec_i;
        kif.rk_ready = 1'b1;
        @(negedge clk);
        kif.start = 1'b0;
        check({name, " busy_after_start"}, 128'(kif.busy), 128'd1);
        check({name, " valid_low_expand"}, 128'(kif.rk_valid), 128'd0);

        cyc = 0;
        while (!kif.rk_valid && cyc < 40) begin
            if (inject && cyc == 3) begin
                kif.start  = 1'b1;
                kif.key_in = ~key;
                kif.dec    = ~dec_i;
            end else begin
                kif.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        kif.start = 1'b0;
        check({name, " valid_latency"}, 128'(cyc), 128'd10);

        k        = 0;
        cyc      = 0;
        stalled  = 1'b0;
        saw_done = 1'b0;
        while (k < 11 && cyc < 400) begin
            if (stalled) begin
                check({name, " stall_out_stable"}, kif.rk_out, prev_out);
                check({name, " stall_round_stable"}, 128'(kif.rk_round), 128'(prev_round));
            end
            if (kif.done) saw_done = 1'b1;
            kif.start = 1'b0;
            if (inject && k == 3) begin
                kif.start  = 1'b1;
                kif.key_in = ~key;
            end
            if (rnd) rdy = (cyc == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
            else     rdy = 1'b1;
            kif.rk_ready = rdy;
            if (rdy) begin
                idx = dec_i ? (10 - k) : k;
                check({name, " beat_valid"}, 128'(kif.rk_valid), 128'd1);
                check({name, " beat_round"}, 128'(kif.rk_round), 128'(idx));
                if (use_zero) begin
                    if (zero_known[idx]) check({name, " beat_key"}, kif.rk_out, zero_tbl[idx]);
                end else begin
                    check({name, " beat_key"}, kif.rk_out, fips_tbl[idx]);
                end
                if (inject && k == 10) begin
                    kif.start  = 1'b1;
                    kif.key_in = ~key;
                end
                k++;
                stalled = 1'b0;
            end else begin
                stalled    = 1'b1;
                prev_out   = kif.rk_out;
                prev_round = kif.rk_round;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < 11) check({name, " handshake_timeout"}, 128'(k), 128'd11);
        kif.start    = 1'b0;
        kif.rk_ready = 1'b0;
        check({name, " done_pulse"}, 128'(kif.done), 128'd1);
        check({name, " no_early_done"}, 128'(saw_done), 128'd0);
        check({name, " busy_low_end"}, 128'(kif.busy), 128'd0);
        check({name, " valid_low_end"}, 128'(kif.rk_valid), 128'd0);
        @(negedge clk);
        check({name, " done_one_cycle"}, 128'(kif.done), 128'd0);
        check({name, " still_idle"}, 128'(kif.busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  bad;
        errors = 0;
        checks = 0;

        fips_tbl[0]  = c_fips_key;
        fips_tbl[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_tbl[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_tbl[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_tbl[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_tbl[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_tbl[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_tbl[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_tbl[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_tbl[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_tbl[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        for (int i = 0; i < 11; i++) begin
            zero_tbl[i]   = '0;
            zero_known[i] = 1'b0;
        end
        zero_known[0] = 1'b1;
        zero_known[1] = 1'b1;
        zero_tbl[1]   = 128'h62636363626363636263636362636363;
        zero_known[10] = 1'b1;
        zero_tbl[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        rst_n        = 1'b0;
        kif.start    = 1'b0;
        kif.key_in   = '0;
        kif.dec      = 1'b0;
        kif.rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rk_valid", 128'(kif.rk_valid), 128'd0);
        check("reset busy", 128'(kif.busy), 128'd0);
        check("reset done", 128'(kif.done), 128'd0);
        check("reset rk_out", kif.rk_out, 128'd0);
        check("reset rk_round", 128'(kif.rk_round), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq("enc", c_fips_key, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("dec", c_fips_key, 1'b1, 1'b0, 1'b1, 1'b1);
        run_seq("enc_stall", c_fips_key, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset pulse while round 5 is being written
        kif.start  = 1'b1;
        kif.key_in = c_fips_key;
        kif.dec    = 1'b0;
        @(negedge clk);
        kif.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort rk_valid", 128'(kif.rk_valid), 128'd0);
        check("abort busy", 128'(kif.busy), 128'd0);
        check("abort done", 128'(kif.done), 128'd0);
        check("abort rk_out", kif.rk_out, 128'd0);
        check("abort rk_round", 128'(kif.rk_round), 128'd0);
        bad = 1'b0;
        for (cnt = 0; cnt < 20; cnt++) begin
            @(negedge clk);
            if (kif.done || kif.rk_valid || kif.busy) bad = 1'b1;
        end
        check("abort stays idle", 128'(bad), 128'd0);

        run_seq("after_abort", c_fips_key, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("zero_key", 128'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
